// File: rtl/obi_dual_port_ram_bridge.sv
// OBI front-end for a simple-dual-port byte-write RAM. Data writes use port A.
// Instruction and data reads share port B through a round-robin arbiter, with byte-wise read-during-write forwarding.
module obi_dual_port_ram_bridge #(
  parameter int ADDR_WIDTH = 17,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addra_o,
  output logic [31:0]           ram_dina_o,
  output logic [3:0]            ram_wea_o,
  output logic [ADDR_WIDTH-1:0] ram_addrb_o,
  output logic                  ram_enb_o,
  output logic                  ram_regceb_o,
  output logic                  ram_rstb_o,
  input  logic [31:0]           ram_doutb_i
);

  typedef enum logic {PTR_DATA = 1'b0, PTR_INSTR = 1'b1} rr_ptr_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic        fwd_en;
    logic [3:0]  fwd_be;
    logic [31:0] fwd_data;
  } resp_t;

  rr_ptr_e r_rr_ptr;
  resp_t   r_ipipe [RD_LATENCY];
  resp_t   r_dpipe [RD_LATENCY];

  logic                  w_instr_rd;
  logic                  w_data_rd;
  logic                  w_data_wr;
  logic                  w_contend;
  logic                  w_instr_gnt;
  logic                  w_data_rd_gnt;
  logic                  w_fwd;
  logic [ADDR_WIDTH-1:0] w_iword;
  logic [ADDR_WIDTH-1:0] w_dword;
  resp_t                 w_inew;
  resp_t                 w_dnew;
  resp_t                 w_iout;
  resp_t                 w_dout;
  logic                  w_unused;

  assign w_iword  = instr_addr_i[ADDR_WIDTH+1:2];
  assign w_dword  = data_addr_i[ADDR_WIDTH+1:2];
  assign w_unused = ^{instr_addr_i[1:0], instr_addr_i[31:ADDR_WIDTH+2],
                      data_addr_i[1:0], data_addr_i[31:ADDR_WIDTH+2]};

  // Requests are masked while reset is held so nothing is granted or written.
  assign w_instr_rd    = instr_req_i & ~rstb;
  assign w_data_rd     = data_req_i & ~data_we_i & ~rstb;
  assign w_data_wr     = data_req_i & data_we_i & ~rstb;
  assign w_contend     = w_instr_rd & w_data_rd;
  assign w_instr_gnt   = w_instr_rd & (~w_contend | (r_rr_ptr == PTR_INSTR));
  assign w_data_rd_gnt = w_data_rd & (~w_contend | (r_rr_ptr == PTR_DATA));
  assign w_fwd         = w_instr_gnt & w_data_wr & (w_iword == w_dword);

  assign instr_gnt_o  = w_instr_gnt;
  assign data_gnt_o   = w_data_wr | w_data_rd_gnt;

  assign ram_addra_o  = w_dword;
  assign ram_dina_o   = data_wdata_i;
  assign ram_wea_o    = w_data_wr ? data_be_i : 4'h0;
  assign ram_addrb_o  = w_data_rd_gnt ? w_dword : w_iword;
  assign ram_enb_o    = w_instr_gnt | w_data_rd_gnt;
  assign ram_regceb_o = 1'b1;
  assign ram_rstb_o   = rstb;

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    w_inew          = '0;
    w_inew.valid    = w_instr_gnt;
    w_inew.fwd_en   = w_fwd;
    w_inew.fwd_be   = data_be_i;
    w_inew.fwd_data = data_wdata_i;
    w_dnew          = '0;
    w_dnew.valid    = w_data_wr | w_data_rd_gnt;
    w_dnew.is_write = w_data_wr;
  end

  // NOTE: sequential state uses non-blocking assignments; whole pipeline entries are
  // cleared on reset (they are registers, not RAM) so in-flight responses are dropped.
  always_ff @(posedge clka) begin
    if (rstb) begin
      r_rr_ptr <= PTR_DATA;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_ipipe[i] <= '0;
        r_dpipe[i] <= '0;
      end
    end else begin
      if (w_contend) r_rr_ptr <= w_instr_gnt ? PTR_DATA : PTR_INSTR;
      r_ipipe[0] <= w_inew;
      r_dpipe[0] <= w_dnew;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_ipipe[i] <= r_ipipe[i-1];
        r_dpipe[i] <= r_dpipe[i-1];
      end
    end
  end

  function automatic logic [31:0] merge_bytes(input resp_t e, input logic [31:0] ram);
    logic [31:0] m;
    for (int b = 0; b < 4; b++)
      m[8*b +: 8] = (e.fwd_en && e.fwd_be[b]) ? e.fwd_data[8*b +: 8] : ram[8*b +: 8];
    return m;
  endfunction

  assign w_iout = r_ipipe[RD_LATENCY-1];
  assign w_dout = r_dpipe[RD_LATENCY-1];

  // Outputs are masked during reset so a response in flight never surfaces.
  assign instr_rvalid_o = w_iout.valid & ~rstb;
  assign data_rvalid_o  = w_dout.valid & ~rstb;
  assign instr_rdata_o  = (instr_rvalid_o && !w_iout.is_write) ? merge_bytes(w_iout, ram_doutb_i) : 32'h0;
  assign data_rdata_o   = (data_rvalid_o && !w_dout.is_write) ? merge_bytes(w_dout, ram_doutb_i) : 32'h0;

endmodule

// File: tb/tb_obi_dual_port_ram_bridge.sv
// Bench for obi_dual_port_ram_bridge: two instances (RD_LATENCY 1 and 2) share one stimulus
// and are compared against a word-array memory model with a per-cycle response schedule.
module tb_obi_dual_port_ram_bridge;
  localparam int AW = 12;

  logic        clka;
  logic        rstb;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;

  logic        igt [2];
  logic        dgt [2];
  logic        irv [2];
  logic        drv [2];
  logic [31:0] ird [2];
  logic [31:0] drd [2];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] ref_mem [2**AW];
  logic        ref_ptr;
  logic        exp_iv [2][4];
  logic        exp_dv [2][4];
  logic [31:0] exp_id [2][4];
  logic [31:0] exp_dd [2][4];
  logic        last_dg;

  initial clka = 1'b0;
  always #5 clka = ~clka;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int L = k + 1;
    logic [AW-1:0] addra, addrb;
    logic [31:0]   dina, doutb, rd1, rd2;
    logic [3:0]    wea;
    logic          enb, regceb, rrst;
    logic [31:0]   mem [2**AW];

    obi_dual_port_ram_bridge #(.ADDR_WIDTH(AW), .RD_LATENCY(L)) u_dut (
      .clka(clka), .rstb(rstb),
      .instr_req_i(instr_req_i), .instr_gnt_o(igt[k]), .instr_addr_i(instr_addr_i),
      .instr_rvalid_o(irv[k]), .instr_rdata_o(ird[k]),
      .data_req_i(data_req_i), .data_gnt_o(dgt[k]), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(drv[k]), .data_rdata_o(drd[k]),
      .ram_addra_o(addra), .ram_dina_o(dina), .ram_wea_o(wea),
      .ram_addrb_o(addrb), .ram_enb_o(enb), .ram_regceb_o(regceb),
      .ram_rstb_o(rrst), .ram_doutb_i(doutb)
    );

    initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = 32'h0;
      rd1 = 32'h0;
      rd2 = 32'h0;
    end

    // Read-first RAM: the read register samples the pre-write contents.
    always @(posedge clka) begin
      for (int b = 0; b < 4; b++)
        if (wea[b]) mem[addra][8*b +: 8] <= dina[8*b +: 8];
      if (enb) rd1 <= mem[addrb];
      if (regceb) rd2 <= rd1;
    end

    assign doutb = (L == 1) ? rd1 : rd2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge.
  task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic dwe, input logic [3:0] be,
                      input logic [31:0] daddr, input logic [31:0] wdata);
    logic e_ig, e_dg, d_rd;
    int   s, t;
    rstb = rst; instr_req_i = ireq; instr_addr_i = iaddr;
    data_req_i = dreq; data_we_i = dwe; data_be_i = be;
    data_addr_i = daddr; data_wdata_i = wdata;
    #1;
    s    = cyc % 4;
    d_rd = dreq && !dwe;
    e_ig = !rst && ireq && (!d_rd || ref_ptr);
    e_dg = !rst && dreq && (dwe || !ireq || !ref_ptr);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("L%0d c%0d instr_gnt", k+1, cyc), {31'h0, igt[k]}, {31'h0, e_ig});
      check($sformatf("L%0d c%0d data_gnt", k+1, cyc), {31'h0, dgt[k]}, {31'h0, e_dg});
      check($sformatf("L%0d c%0d instr_rvalid", k+1, cyc), {31'h0, irv[k]}, {31'h0, !rst && exp_iv[k][s]});
      check($sformatf("L%0d c%0d instr_rdata", k+1, cyc), ird[k], rst ? 32'h0 : exp_id[k][s]);
      check($sformatf("L%0d c%0d data_rvalid", k+1, cyc), {31'h0, drv[k]}, {31'h0, !rst && exp_dv[k][s]});
      check($sformatf("L%0d c%0d data_rdata", k+1, cyc), drd[k], rst ? 32'h0 : exp_dd[k][s]);
      exp_iv[k][s] = 1'b0; exp_id[k][s] = 32'h0;
      exp_dv[k][s] = 1'b0; exp_dd[k][s] = 32'h0;
    end
    last_dg = dgt[0];
    if (rst) begin
      ref_ptr = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < 4; j++) begin
          exp_iv[k][j] = 1'b0; exp_id[k][j] = 32'h0;
          exp_dv[k][j] = 1'b0; exp_dd[k][j] = 32'h0;
        end
    end else begin
      if (ireq && d_rd) ref_ptr = e_dg;
      if (e_dg && dwe)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[daddr[AW+1:2]][8*b +: 8] = wdata[8*b +: 8];
      for (int k = 0; k < 2; k++) begin
        t = (cyc + k + 1) % 4;
        if (e_ig) begin
          exp_iv[k][t] = 1'b1;
          exp_id[k][t] = ref_mem[iaddr[AW+1:2]];
        end
        if (e_dg) begin
          exp_dv[k][t] = 1'b1;
          exp_dd[k][t] = dwe ? 32'h0 : ref_mem[daddr[AW+1:2]];
        end
      end
    end
    @(posedge clka);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[AW+1:6] = '0;
    return a;
  endfunction

  initial begin
    logic [3:0] pat;
    logic [31:0] a, b;
    ref_ptr = 1'b0;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = 32'h0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++) begin
        exp_iv[k][j] = 1'b0; exp_id[k][j] = 32'h0;
        exp_dv[k][j] = 1'b0; exp_dd[k][j] = 32'h0;
      end

    step(1, 0, 0, 0, 0, 4'h0, 0, 0);
    step(1, 0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Single write then read
    step(0, 0, 0, 1, 1, 4'hF, 32'h1000, 32'hDEADBEEF);
    check("wr resp valid L1", {31'h0, drv[0]}, 32'h1);
    check("wr resp rdata L1", drd[0], 32'h0);
    step(0, 0, 0, 1, 0, 4'h0, 32'h1000, 0);
    check("rd 0x1000 L1", drd[0], 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    check("rd 0x1000 L2", drd[1], 32'hDEADBEEF);

    // Byte write on byte lane 1
    step(0, 0, 0, 1, 1, 4'h2, 32'h1000, 32'h0000AA00);
    step(0, 0, 0, 1, 0, 4'h0, 32'h1000, 0);
    check("byte write L1", drd[0], 32'hDEADAAEF);

    // Forwarding: instruction read and same-word data write together
    step(0, 0, 0, 1, 1, 4'hF, 32'h2000, 32'h11111111);
    step(0, 1, 32'h2000, 1, 1, 4'h5, 32'h2000, 32'h22222222);
    check("fwd valid L1", {31'h0, irv[0]}, 32'h1);
    check("fwd rdata L1", ird[0], 32'h11221122);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    check("fwd rdata L2", ird[1], 32'h11221122);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Contention: grants alternate starting with data
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h1000, 1, 0, 4'h0, 32'h2000, 0);
      check($sformatf("contention data_gnt %0d", i), {31'h0, last_dg}, {31'h0, pat[i]});
    end
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Ordering at latency 2: read then write on consecutive cycles
    step(0, 0, 0, 1, 0, 4'h0, 32'h1000, 0);
    step(0, 0, 0, 1, 1, 4'hF, 32'h1004, 32'h12345678);
    check("order rd valid L2", {31'h0, drv[1]}, 32'h1);
    check("order rd data L2", drd[1], 32'hDEADAAEF);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    check("order wr valid L2", {31'h0, drv[1]}, 32'h1);
    check("order wr data L2", drd[1], 32'h0);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Reset one cycle after a read grant drops that response
    step(0, 1, 32'h2000, 1, 0, 4'h0, 32'h1000, 0);
    step(1, 0, 0, 0, 0, 4'h0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("post-reset instr_rvalid L%0d", k+1), {31'h0, irv[k]}, 32'h0);
      check($sformatf("post-reset data_rvalid L%0d", k+1), {31'h0, drv[k]}, 32'h0);
      check($sformatf("post-reset instr_rdata L%0d", k+1), ird[k], 32'h0);
      check($sformatf("post-reset data_rdata L%0d", k+1), drd[k], 32'h0);
    end
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Randomized traffic in a small aliased window to provoke contention and forwarding
    for (int i = 0; i < 400; i++) begin
      a = rand_addr();
      b = ($urandom_range(0, 3) == 0) ? (a ^ 32'hFFFF_C003) : rand_addr();
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), a,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
           b, $urandom);
    end
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
